tof_frame_buffer: RTL and testbench
===================================

TOF_FRAME_BUFFER -- requirements
Module: tof_frame_buffer

Interface
REQ-001 SHALL have parameter NB_ZONES, default 64, meaning zones per frame (8x8 grid).
REQ-002 SHALL have parameter DIST_W, default 16, meaning distance word width in mm.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port distance_data  input  DIST_W  zone distance from the ToF sensor FSM.
REQ-006 SHALL have port sensor_index  input  6  zone index of distance_data.
REQ-007 SHALL have port data_ready  input  1  level from the sensor FSM; a new zone is marked by its rising edge.
REQ-008 SHALL have port hold  input  1  high = freeze the front bank and suppress bank swaps.
REQ-009 SHALL have port rd_en  input  1  read request on the front bank.
REQ-010 SHALL have port rd_addr  input  6  zone to read.
REQ-011 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-012 SHALL have port rd_data  output  DIST_W  read data.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-014 SHALL have port frame_valid  output  1  one-cycle pulse: new frame swapped to the front.
REQ-015 SHALL have port frame_count  output  16  number of frames swapped.
REQ-016 SHALL have port min_dist  output  DIST_W  minimum non-zero distance of the front frame.
REQ-017 SHALL have port min_index  output  6  zone of min_dist.
REQ-018 SHALL have port frame_err  output  1  sticky: a frame closed with missing zones.
REQ-019 SHALL have port dup_err  output  1  sticky: a zone was written twice in one frame.
REQ-020 SHALL have port drop_err  output  1  sticky: a frame was discarded while hold=1.

Function
REQ-021 SHALL register data_ready and detect its rising edge (wr_stb): wr_stb high when data_ready=1 and the registered copy=0, at most one write per edge.
REQ-022 SHALL, on wr_stb, capture distance_data and sensor_index in the same cycle and write the distance into the back bank at sensor_index.
REQ-023 SHALL keep two banks of NB_ZONES x DIST_W plus a 1-bit bank select; the front bank is readable and the back bank is written.
REQ-024 SHALL keep a NB_ZONES-bit written mask per back frame; on a write whose mask bit is already set, overwrite the data and set dup_err.
REQ-025 SHALL keep a running minimum: on wr_stb with distance!=0 and distance<run_min, update run_min and run_idx; zero distances are excluded; ties keep the lower-arrival (first) zone.
REQ-026 SHALL close the frame on the wr_stb with sensor_index==NB_ZONES-1, using the updated mask and minimum of that same write.
REQ-027 SHALL, on frame close with hold=0, on the next clock: toggle the bank select; pulse frame_valid for 1 cycle; increment frame_count (wraps 16'hFFFF->0); load min_dist/min_index from run_min/run_idx (16'hFFFF/0 if no non-zero zone).
REQ-028 SHALL set frame_err on close if the mask is not all ones; the swap still occurs.
REQ-029 SHALL, on close with hold=1, perform no swap, no frame_valid, no count or min update, and set drop_err.
REQ-030 SHALL, on every close, clear the mask and set run_min=all ones, run_idx=0, so the next frame starts clean.
REQ-031 SHALL process rd_en: rd_data = front[rd_addr] and rd_valid=1 exactly one cycle later; the bank used is the front bank at the rd_en cycle, even if a swap occurs that cycle; rd_valid=0 otherwise; rd_data holds its last value.
REQ-032 SHALL accept rd_en every cycle (throughput 1 read/cycle), independent of writes.
REQ-033 SHALL clear all sticky errors on clr_err; a set event in the same cycle wins over clr_err.
REQ-034 SHALL treat out-of-range sensor_index (>=NB_ZONES when NB_ZONES<64) as ignored, setting frame_err.

Reset
REQ-035 SHALL, with reset high at a clock edge, clear to 0: bank select, mask, edge register, rd_data, rd_valid, frame_valid, frame_count, min_index, run_idx and all error flags.
REQ-036 SHALL, with reset high, set min_dist and run_min to all ones.
REQ-037 SHALL not require bank contents to be cleared; reads before the first frame return don't-care data.
REQ-038 SHALL abort a partially collected frame on reset mid-frame, with no frame_valid.

Verification
REQ-039 Scenario: 64 edges, index 0..63, distance=100+index, hold=0 -> one frame_valid pulse, frame_count=1, min_dist=100, min_index=0; rd_addr=5 -> rd_data=105 one cycle later.
REQ-040 Scenario: frame with zone 10=0 and zone 20=7, others 50 -> min_dist=7, min_index=20, frame_err=0.
REQ-041 Scenario: indices 0..62 skipping 30, then 63 -> swap occurs, frame_err=1; clr_err -> frame_err=0.
REQ-042 Scenario: index 3 written twice (values 9 then 40) -> dup_err=1, read of zone 3 after swap = 40.
REQ-043 Scenario: hold=1 during a full frame -> no frame_valid, frame_count unchanged, drop_err=1, front bank reads unchanged.
REQ-044 Scenario: data_ready held high for 5 cycles -> exactly one write; reset after 20 zones, then a full frame -> frame_count=1, frame_err=0.

Source files
------------

// File: rtl/tof_frame_buffer.sv
// Double-buffered 8x8 ToF distance frame store: a sensor FSM fills the back bank
// while the front bank is read, with frame statistics and sticky error flags.
module tof_frame_buffer #(
  parameter int NB_ZONES = 64,
  parameter int DIST_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIST_W-1:0] distance_data,
  input  logic [5:0]        sensor_index,
  input  logic              data_ready,
  input  logic              hold,
  input  logic              rd_en,
  input  logic [5:0]        rd_addr,
  input  logic              clr_err,
  output logic [DIST_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_valid,
  output logic [15:0]       frame_count,
  output logic [DIST_W-1:0] min_dist,
  output logic [5:0]        min_index,
  output logic              frame_err,
  output logic              dup_err,
  output logic              drop_err
);

  logic                r_dr;
  logic                r_sel;
  logic [NB_ZONES-1:0] r_mask;
  logic [DIST_W-1:0]   r_run_min;
  logic [5:0]          r_run_idx;
  logic [DIST_W-1:0]   r_bank0 [NB_ZONES];
  logic [DIST_W-1:0]   r_bank1 [NB_ZONES];

  logic                w_wr_stb;
  logic                w_idx_ok;
  logic                w_rd_ok;
  logic [NB_ZONES-1:0] w_onehot;
  logic [NB_ZONES-1:0] w_mask_nxt;
  logic                w_dup;
  logic                w_min_upd;
  logic [DIST_W-1:0]   w_min_nxt;
  logic [5:0]          w_idx_nxt;
  logic                w_close;
  logic                w_set_ferr;
  logic                w_set_dup;
  logic                w_set_drop;
  logic [DIST_W-1:0]   w_front;

  assign w_wr_stb   = data_ready && !r_dr;
  assign w_idx_ok   = ({1'b0, sensor_index} < 7'(NB_ZONES));
  assign w_rd_ok    = ({1'b0, rd_addr} < 7'(NB_ZONES));
  assign w_onehot   = w_idx_ok ? ({{(NB_ZONES-1){1'b0}}, 1'b1} << sensor_index) : '0;
  assign w_mask_nxt = r_mask | w_onehot;
  assign w_dup      = |(r_mask & w_onehot);

  // Zero distances mean "no return" and never win; strict < keeps the first tie.
  assign w_min_upd  = w_idx_ok && (distance_data != '0) && (distance_data < r_run_min);
  assign w_min_nxt  = w_min_upd ? distance_data : r_run_min;
  assign w_idx_nxt  = w_min_upd ? sensor_index : r_run_idx;

  assign w_close    = w_wr_stb && (sensor_index == 6'(NB_ZONES-1));
  assign w_set_ferr = (w_wr_stb && !w_idx_ok) || (w_close && !(&w_mask_nxt));
  assign w_set_dup  = w_wr_stb && w_dup;
  assign w_set_drop = w_close && hold;

  assign w_front    = r_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];

  // Back-bank write: r_sel=0 means bank0 is front, so bank1 collects.
  always_ff @(posedge clk) begin
    if (w_wr_stb && w_idx_ok) begin
      if (r_sel) r_bank0[sensor_index] <= distance_data;
      else       r_bank1[sensor_index] <= distance_data;
    end
  end

  // Read port: uses r_sel before any swap taking effect on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= w_rd_ok ? w_front : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dr        <= 1'b0;
      r_sel       <= 1'b0;
      r_mask      <= '0;
      r_run_min   <= '1;
      r_run_idx   <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      min_dist    <= '1;
      min_index   <= '0;
      frame_err   <= 1'b0;
      dup_err     <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      r_dr        <= data_ready;
      frame_valid <= 1'b0;
      if (w_close) begin
        r_mask    <= '0;
        r_run_min <= '1;
        r_run_idx <= '0;
        if (!hold) begin
          r_sel       <= ~r_sel;
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
          min_dist    <= w_min_nxt;
          min_index   <= w_idx_nxt;
        end
      end else if (w_wr_stb) begin
        r_mask    <= w_mask_nxt;
        r_run_min <= w_min_nxt;
        r_run_idx <= w_idx_nxt;
      end
      // A set event in the same cycle as clr_err wins.
      frame_err <= (frame_err && !clr_err) || w_set_ferr;
      dup_err   <= (dup_err   && !clr_err) || w_set_dup;
      drop_err  <= (drop_err  && !clr_err) || w_set_drop;
    end
  end

endmodule

// File: tb/tb_tof_frame_buffer.sv
// Directed bench for tof_frame_buffer: bank model plus a read scoreboard queue.
module tb_tof_frame_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] distance_data;
  logic [5:0]  sensor_index;
  logic        data_ready;
  logic        hold;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        clr_err;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        frame_valid;
  logic [15:0] frame_count;
  logic [15:0] min_dist;
  logic [5:0]  min_index;
  logic        frame_err;
  logic        dup_err;
  logic        drop_err;

  tof_frame_buffer #(.NB_ZONES(64), .DIST_W(16)) dut (
    .clk(clk), .reset(reset), .distance_data(distance_data),
    .sensor_index(sensor_index), .data_ready(data_ready), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .clr_err(clr_err), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_valid(frame_valid), .frame_count(frame_count),
    .min_dist(min_dist), .min_index(min_index), .frame_err(frame_err),
    .dup_err(dup_err), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_t;

  rd_t         exp_q[$];
  logic [15:0] m_bank [2][64];
  bit          m_sel;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          fv_cnt = 0;
  bit          mon_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        rd_t e;
        e = exp_q.pop_front();
        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd_data", {16'd0, rd_data}, {16'd0, e.val});
      end else if (rd_valid !== 1'b0) begin
        chk("rd_spurious", {31'd0, rd_valid}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_sel = 1'b0;
  endtask

  task automatic wr(input int idx, input int d, input bit clr = 1'b0,
                    input bit rde = 1'b0, input int ra = 0);
    distance_data = 16'(d);
    sensor_index  = 6'(idx);
    data_ready    = 1'b1;
    clr_err       = clr;
    if (rde) begin
      rd_en   = 1'b1;
      rd_addr = 6'(ra);
      exp_q.push_back('{due: cyc + 1, val: m_bank[m_sel][ra]});
    end
    m_bank[m_sel ? 0 : 1][idx] = 16'(d);
    if (idx == 63 && !hold) m_sel = !m_sel;
    tick();
    data_ready = 1'b0;
    clr_err    = 1'b0;
    rd_en      = 1'b0;
    tick();
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = 6'(a);
    exp_q.push_back('{due: cyc + 1, val: m_bank[m_sel][a]});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    tick();
    tick();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; distance_data = '0; sensor_index = '0; data_ready = 1'b0;
    hold = 1'b0; rd_en = 1'b0; rd_addr = '0; clr_err = 1'b0;
    for (int b = 0; b < 2; b++) for (int z = 0; z < 64; z++) m_bank[b][z] = '0;
    do_reset();
    mon_on = 1'b1;

    chk("rst_count", frame_count, 0);
    chk("rst_min", min_dist, 16'hFFFF);
    chk("rst_minidx", min_index, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_rvalid", rd_valid, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_errs", {frame_err, dup_err, drop_err}, 0);

    // Full ascending frame
    for (int i = 0; i < 64; i++) wr(i, 100 + i);
    chk("s1_fv", fv_cnt, 1);
    chk("s1_count", frame_count, 1);
    chk("s1_min", min_dist, 100);
    chk("s1_minidx", min_index, 0);
    chk("s1_ferr", frame_err, 0);
    rd(5);
    rd(0);
    rd(63);
    drain("s1_drain");

    // Zero excluded, minimum in the middle, later tie ignored
    for (int i = 0; i < 64; i++) wr(i, (i == 10) ? 0 : (i == 20 || i == 40) ? 7 : 50);
    chk("s2_fv", fv_cnt, 2);
    chk("s2_count", frame_count, 2);
    chk("s2_min", min_dist, 7);
    chk("s2_minidx", min_index, 20);
    chk("s2_ferr", frame_err, 0);
    rd(10);
    rd(20);
    drain("s2_drain");

    // Missing zone 30
    for (int i = 0; i < 64; i++) if (i != 30) wr(i, 200 + i);
    chk("s3_fv", fv_cnt, 3);
    chk("s3_count", frame_count, 3);
    chk("s3_ferr", frame_err, 1);
    chk("s3_min", min_dist, 200);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s3_ferr_clr", frame_err, 0);
    rd(29);
    drain("s3_drain");

    // Zone 3 written twice, second write coincides with clr_err
    for (int i = 0; i < 63; i++) wr(i, (i == 3) ? 9 : 300);
    wr(3, 40, 1'b1);
    chk("s4_dup_set_wins", dup_err, 1);
    wr(63, 300);
    chk("s4_count", frame_count, 4);
    chk("s4_ferr", frame_err, 0);
    rd(3);
    rd(4);
    drain("s4_drain");

    // Held frame is dropped
    hold = 1'b1;
    for (int i = 0; i < 64; i++) wr(i, 500 + i);
    hold = 1'b0;
    chk("s5_fv", fv_cnt, 4);
    chk("s5_count", frame_count, 4);
    chk("s5_drop", drop_err, 1);
    chk("s5_minidx", min_index, 3);
    rd(3);
    rd(5);
    drain("s5_drain");

    // data_ready held high: one write only
    distance_data = 16'd77; sensor_index = 6'd0; data_ready = 1'b1;
    m_bank[m_sel ? 0 : 1][0] = 16'd77;
    repeat (5) tick();
    data_ready = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int i = 1; i < 20; i++) wr(i, 700 + i);
    chk("s6_single_write", dup_err, 0);

    // Reset mid-frame, then a full frame with a read on the swap cycle
    do_reset();
    chk("s6_rst_count", frame_count, 0);
    chk("s6_rst_min", min_dist, 16'hFFFF);
    for (int i = 0; i < 63; i++) wr(i, 600 + i);
    chk("s6_no_fv", fv_cnt, 4);
    wr(63, 663, 1'b0, 1'b1, 1);
    chk("s6_fv", fv_cnt, 5);
    chk("s6_count", frame_count, 1);
    chk("s6_ferr", frame_err, 0);
    chk("s6_min", min_dist, 600);
    rd(1);
    rd(63);
    drain("s6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
